mdp3_feed_arbiter: RTL
======================

// Module: mdp3_feed_arbiter
// PURPOSE
//  A/B feed arbiter and sequencer in front of MDP3_Parser. Takes two redundant 64-bit message
//  streams (CME feed A / feed B). Forwards each sequence number once, in order, to the parser.
//  Drops stale/duplicate copies and flags sequence gaps. Owns the parser's data_valid/parser_ready handshake.
// PARAMETERS
//  DATA_W        64  beat width; must match parser MESSAGE width
//  BEATS_PER_MSG 6   fixed beats per message (beat 0 carries seq number)
//  SEQ_W         32  sequence number width
//  DUP_CNT_W     16  width of saturating drop counter
// PORTS
//  clk          in   1          clock; all logic on posedge
//  reset        in   1          synchronous, active-high reset
//  a_valid      in   1          feed A beat valid
//  a_data       in   DATA_W     feed A beat
//  a_ready      out  1          feed A beat accepted when a_valid&&a_ready
//  b_valid      in   1          feed B beat valid
//  b_data       in   DATA_W     feed B beat
//  b_ready      out  1          feed B beat accepted when b_valid&&b_ready
//  data_valid   out  1          to parser data_valid
//  MESSAGE      out  DATA_W     to parser MESSAGE
//  parser_ready in   1          from parser; beat transfers when data_valid&&parser_ready
//  msg_last     out  1          high with final beat of a forwarded message
//  gap_pulse    out  1          1-cycle pulse: forwarded seq != last_seq+1
//  last_seq     out  SEQ_W      seq of most recently forwarded message
//  drop_count   out  DUP_CNT_W  messages discarded (saturates at all-ones)
// BEHAVIOUR
//  Reset: state=IDLE, beat_cnt=0, seen_first=0, last_seq=0, drop_count=0, sel=A, rr=A;
//   outputs a_ready=b_ready=data_valid=msg_last=gap_pulse=0. Mid-message reset abandons the message;
//   upstream is reset simultaneously.
//  Seq extraction: seq = byteswap32(beat0[63:32]) (wire is little-endian).
//  Newer test (wrap-safe): newer(s) = !seen_first || $signed(s - last_seq) > 0 (SEQ_W-bit modular).
//  FSM IDLE -> FWD | DROP -> IDLE:
//   IDLE: readies low; inspect valid feeds' beat 0 (not consumed). Decide in 1 cycle:
//    - one feed valid: FWD if newer(seq) else DROP.
//    - both valid, both newer: FWD lower seq (modular compare). Equal seq: FWD rr-preferred feed.
//    - both valid, one newer: FWD that one.
//    - both valid, neither newer: DROP rr-preferred feed.
//    - rr toggles after every tie-break use.
//    - on FWD decision: last_seq<=seq, seen_first<=1.
//    - gap_pulse<=1 if seen_first && seq!=last_seq+1.
//    - on DROP decision: drop_count++ (saturating).
//   FWD: data_valid=sel_valid; MESSAGE=sel_data; sel_ready=parser_ready; other feed ready=0.
//    beat_cnt++ per transfer; msg_last=(beat_cnt==BEATS_PER_MSG-1); last transfer -> IDLE, beat_cnt=0.
//   DROP: sel_ready=1, data_valid=0; consume BEATS_PER_MSG beats at 1/cycle when valid, then IDLE.
//  Latency: first beat on MESSAGE 1 cycle after beat 0 is presented in IDLE.
//   Then combinational pass-through, 1 beat/cycle while parser_ready held.
//  Bubbles: feed valid low or parser_ready low mid-message stalls; beat_cnt holds; no reorder.
//  Unselected feed is never consumed during FWD/DROP (backpressured; no loss).
//  Simultaneous: gap_pulse and drop_count never change in same cycle (one decision per IDLE).
// STRUCTURE
//  mdp3_pkg: typedef enum {ARB_IDLE, ARB_FWD, ARB_DROP} arb_state_t;
//   localparam MDP3_BEATS_PER_MSG=6; function mdp3_seq_of(beat) with byteswap.
//  One sub-module: mdp3_seq_cmp (comb): inputs seq_a, seq_b, last_seq, seen_first.
//   Outputs newer_a, newer_b, a_lt_b. Instantiated once in IDLE decision logic.
//  Top: FSM, beat counter, rr bit, output mux.
// TESTING
//  1 A only seq 100..102, parser_ready=1 -> 18 beats forwarded in order, msg_last every 6th, no gap, drop_count=0.
//  2 A and B both seq 100 same cycle, rr=A -> A forwarded once, B dropped; drop_count=1, rr=B.
//  3 A seq 105 after last_seq=100 -> forwarded, gap_pulse 1 cycle, last_seq=105.
//  4 last_seq=0xFFFFFFFF, B seq 0x00000000 -> forwarded (wrap), no gap; A then seq 0xFFFFFFFE -> dropped.
//  5 parser_ready low 3 cycles at beat 2 -> MESSAGE holds beat 2; a_ready low; resumes; no beat lost/duplicated.
//  6 reset asserted at beat 3 of FWD -> next cycle IDLE, data_valid=0, drop_count=0, seen_first=0.

Source files
------------

// File: rtl/mdp3_pkg.sv
// rtl/mdp3_pkg.sv - shared types and helpers for the MDP3 feed arbiter
//
// Purpose: arbiter FSM state type, default message length and the
// sequence-number extraction helper used on beat 0 of every message.

package mdp3_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_FWD,
    ARB_DROP
  } arb_state_t;

  localparam int MDP3_BEATS_PER_MSG = 6;

  // The sequence number sits little-endian in the upper word of beat 0.
  function automatic logic [31:0] mdp3_seq_of(input logic [63:0] beat);
    return {beat[39:32], beat[47:40], beat[55:48], beat[63:56]};
  endfunction

endpackage

// File: rtl/mdp3_seq_cmp.sv
// rtl/mdp3_seq_cmp.sv - wrap-safe sequence number comparator
//
// Purpose: decide whether each feed's head sequence number is newer than the
// last forwarded one, and which of the two is lower, using modular
// (serial-number) arithmetic so the comparison survives counter wrap.
// Ports:
//   seq_a, seq_b  in   head sequence numbers of feed A / feed B
//   last_seq      in   most recently forwarded sequence number
//   seen_first    in   a message has been forwarded since reset
//   newer_a/b     out  feed head is ahead of last_seq (always 1 before first)
//   a_lt_b        out  seq_a is behind seq_b in modular order

module mdp3_seq_cmp #(
  parameter int SEQ_W = 32
) (
  input  logic [SEQ_W-1:0] seq_a,
  input  logic [SEQ_W-1:0] seq_b,
  input  logic [SEQ_W-1:0] last_seq,
  input  logic             seen_first,
  output logic             newer_a,
  output logic             newer_b,
  output logic             a_lt_b
);

  logic [SEQ_W-1:0] diff_a;
  logic [SEQ_W-1:0] diff_b;
  logic [SEQ_W-1:0] diff_ab;

  assign diff_a  = seq_a - last_seq;
  assign diff_b  = seq_b - last_seq;
  assign diff_ab = seq_a - seq_b;

  // Signed difference strictly positive: sign bit clear and non-zero.
  assign newer_a = !seen_first || (!diff_a[SEQ_W-1] && (diff_a != '0));
  assign newer_b = !seen_first || (!diff_b[SEQ_W-1] && (diff_b != '0));
  assign a_lt_b  = diff_ab[SEQ_W-1];

endmodule

// File: rtl/mdp3_feed_arbiter.sv
// rtl/mdp3_feed_arbiter.sv - A/B feed arbiter and sequencer ahead of the MDP3 parser
//
// Purpose: merge two redundant message feeds, forwarding every sequence
// number once and in order, discarding stale/duplicate copies and flagging
// sequence gaps.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   a_valid/a_data/a_ready          feed A beat stream
//   b_valid/b_data/b_ready          feed B beat stream
//   data_valid/MESSAGE/parser_ready beat stream to the parser
//   msg_last                        final beat of a forwarded message
//   gap_pulse                       one-cycle pulse on a sequence gap
//   last_seq                        most recently forwarded sequence number
//   drop_count                      saturating count of discarded messages

module mdp3_feed_arbiter
  import mdp3_pkg::*;
#(
  parameter int DATA_W        = 64,
  parameter int BEATS_PER_MSG = MDP3_BEATS_PER_MSG,
  parameter int SEQ_W         = 32,
  parameter int DUP_CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 a_valid,
  input  logic [DATA_W-1:0]    a_data,
  output logic                 a_ready,
  input  logic                 b_valid,
  input  logic [DATA_W-1:0]    b_data,
  output logic                 b_ready,
  output logic                 data_valid,
  output logic [DATA_W-1:0]    MESSAGE,
  input  logic                 parser_ready,
  output logic                 msg_last,
  output logic                 gap_pulse,
  output logic [SEQ_W-1:0]     last_seq,
  output logic [DUP_CNT_W-1:0] drop_count
);

  localparam int              CNT_W     = (BEATS_PER_MSG > 1) ? $clog2(BEATS_PER_MSG) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_MSG - 1);

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] beat_cnt;
  logic             seen_first;
  logic             sel;        // 0 = feed A, 1 = feed B
  logic             rr;         // tie-break preference, 0 = feed A
  logic [SEQ_W-1:0] seq_a, seq_b, dec_seq;
  logic             newer_a, newer_b, a_lt_b;
  logic             dec_go, dec_fwd, dec_sel, dec_tie;
  logic             sel_valid, beat_done;

  assign seq_a = SEQ_W'(mdp3_seq_of(a_data));
  assign seq_b = SEQ_W'(mdp3_seq_of(b_data));

  mdp3_seq_cmp #(.SEQ_W(SEQ_W)) u_seq_cmp (
    .seq_a      (seq_a),
    .seq_b      (seq_b),
    .last_seq   (last_seq),
    .seen_first (seen_first),
    .newer_a    (newer_a),
    .newer_b    (newer_b),
    .a_lt_b     (a_lt_b)
  );

  // IDLE decision on the visible beat 0 of each valid feed; nothing is consumed.
  always_comb begin
    dec_go  = 1'b0;
    dec_fwd = 1'b0;
    dec_sel = 1'b0;
    dec_tie = 1'b0;
    if (a_valid && b_valid) begin
      dec_go = 1'b1;
      if (newer_a && newer_b) begin
        dec_fwd = 1'b1;
        if (seq_a == seq_b) begin
          dec_tie = 1'b1;
          dec_sel = rr;
        end else begin
          dec_sel = !a_lt_b;
        end
      end else if (newer_a) begin
        dec_fwd = 1'b1;
      end else if (newer_b) begin
        dec_fwd = 1'b1;
        dec_sel = 1'b1;
      end else begin
        // Both stale: discard the preferred copy, the other is judged next.
        dec_tie = 1'b1;
        dec_sel = rr;
      end
    end else if (a_valid) begin
      dec_go  = 1'b1;
      dec_fwd = newer_a;
    end else if (b_valid) begin
      dec_go  = 1'b1;
      dec_fwd = newer_b;
      dec_sel = 1'b1;
    end
    dec_seq = dec_sel ? seq_b : seq_a;
  end

  always_comb begin
    state_nxt  = state;
    a_ready    = 1'b0;
    b_ready    = 1'b0;
    data_valid = 1'b0;
    msg_last   = 1'b0;
    beat_done  = 1'b0;
    sel_valid  = sel ? b_valid : a_valid;
    MESSAGE    = sel ? b_data : a_data;
    unique case (state)
      ARB_IDLE: begin
        if (dec_go) state_nxt = dec_fwd ? ARB_FWD : ARB_DROP;
      end
      ARB_FWD: begin
        data_valid = sel_valid;
        a_ready    = !sel && parser_ready;
        b_ready    = sel && parser_ready;
        msg_last   = (beat_cnt == LAST_BEAT);
        beat_done  = sel_valid && parser_ready;
      end
      ARB_DROP: begin
        a_ready   = !sel;
        b_ready   = sel;
        beat_done = sel_valid;
      end
      default: state_nxt = ARB_IDLE;
    endcase
    if (beat_done && (beat_cnt == LAST_BEAT)) state_nxt = ARB_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB_IDLE;
      beat_cnt   <= '0;
      seen_first <= 1'b0;
      last_seq   <= '0;
      drop_count <= '0;
      sel        <= 1'b0;
      rr         <= 1'b0;
      gap_pulse  <= 1'b0;
    end else begin
      state     <= state_nxt;
      gap_pulse <= 1'b0;
      if ((state == ARB_IDLE) && dec_go) begin
        sel <= dec_sel;
        if (dec_tie) rr <= !rr;
        if (dec_fwd) begin
          last_seq   <= dec_seq;
          seen_first <= 1'b1;
          gap_pulse  <= seen_first && (dec_seq != last_seq + 1'b1);
        end else if (drop_count != '1) begin
          drop_count <= drop_count + 1'b1;
        end
      end
      if (beat_done) beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
    end
  end

endmodule
